// File: rtl/ras_ckpt_stack.sv
// Circular return-address stack with multi-slot speculative checkpoints.
// A mispredict restores tail, size and top entry from a checkpoint in one cycle.
module ras_ckpt_stack #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned ENTRY_SIZE  = 64,
  parameter int unsigned NUM_CKPT    = 4,
  localparam int unsigned PW = $clog2(STACK_DEPTH),
  localparam int unsigned SW = $clog2(STACK_DEPTH + 1),
  localparam int unsigned IW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  push_in,
  input  logic                  pop_in,
  input  logic [ENTRY_SIZE-1:0] push_data_in,
  input  logic                  ckpt_req_in,
  output logic                  ckpt_ready_out,
  output logic [IW-1:0]         ckpt_id_out,
  input  logic                  restore_in,
  input  logic [IW-1:0]         restore_id_in,
  input  logic                  release_in,
  input  logic [IW-1:0]         release_id_in,
  output logic [ENTRY_SIZE-1:0] top_out,
  output logic                  empty_out,
  output logic [SW-1:0]         size_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam logic [SW-1:0] FULL = SW'(STACK_DEPTH);

  logic [ENTRY_SIZE-1:0] r_entries [STACK_DEPTH];
  logic [PW-1:0]         r_tail;
  logic [SW-1:0]         r_size;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [NUM_CKPT-1:0]   r_ck_valid;
  logic [PW-1:0]         r_ck_tail [NUM_CKPT];
  logic [SW-1:0]         r_ck_size [NUM_CKPT];
  logic [ENTRY_SIZE-1:0] r_ck_top  [NUM_CKPT];

  logic                  w_rst_ok;
  logic                  w_rel_ok;
  logic [PW-1:0]         w_base_tail;
  logic [SW-1:0]         w_base_size;
  logic [PW-1:0]         w_nxt_tail;
  logic [SW-1:0]         w_nxt_size;
  logic [ENTRY_SIZE-1:0] w_nxt_top;
  logic                  w_wr_en;
  logic [PW-1:0]         w_wr_addr;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_ready;
  logic [IW-1:0]         w_free_id;
  logic                  w_alloc;
  logic [NUM_CKPT-1:0]   w_nxt_valid;

  always_comb begin
    w_rst_ok = 1'b0;
    if (restore_in && (32'(restore_id_in) < NUM_CKPT))
      w_rst_ok = r_ck_valid[restore_id_in];
    w_rel_ok = release_in && (32'(release_id_in) < NUM_CKPT);
  end

  // Push/pop operate on the restored state, so a restore and a call can share a cycle.
  always_comb begin
    w_base_tail = w_rst_ok ? r_ck_tail[restore_id_in] : r_tail;
    w_base_size = w_rst_ok ? r_ck_size[restore_id_in] : r_size;
    w_nxt_tail  = w_base_tail;
    w_nxt_size  = w_base_size;
    w_wr_en     = 1'b0;
    w_wr_addr   = w_base_tail;
    w_ovf       = 1'b0;
    w_unf       = 1'b0;
    if (push_in && (!pop_in || (w_base_size == '0))) begin
      w_nxt_tail = w_base_tail + PW'(1);
      w_wr_en    = 1'b1;
      w_wr_addr  = w_base_tail + PW'(1);
      w_nxt_size = (w_base_size == FULL) ? FULL : w_base_size + SW'(1);
      w_ovf      = (w_base_size == FULL);
      w_unf      = pop_in;
    end else if (push_in) begin
      w_wr_en = 1'b1;
    end else if (pop_in) begin
      if (w_base_size == '0) begin
        w_unf = 1'b1;
      end else begin
        w_nxt_tail = w_base_tail - PW'(1);
        w_nxt_size = w_base_size - SW'(1);
      end
    end
  end

  // Top of the post-update state, forwarding this cycle's pending writes.
  always_comb begin
    if (w_wr_en && (w_wr_addr == w_nxt_tail))
      w_nxt_top = push_data_in;
    else if (w_rst_ok && (r_ck_tail[restore_id_in] == w_nxt_tail))
      w_nxt_top = r_ck_top[restore_id_in];
    else
      w_nxt_top = r_entries[w_nxt_tail];
  end

  always_comb begin
    w_ready   = 1'b0;
    w_free_id = '0;
    for (int unsigned i = 0; i < NUM_CKPT; i++) begin
      if (!r_ck_valid[i] && !w_ready) begin
        w_ready   = 1'b1;
        w_free_id = IW'(i);
      end
    end
    w_alloc     = ckpt_req_in && w_ready;
    w_nxt_valid = r_ck_valid;
    if (w_rst_ok) w_nxt_valid[restore_id_in] = 1'b0;
    if (w_rel_ok) w_nxt_valid[release_id_in] = 1'b0;
    if (w_alloc)  w_nxt_valid[w_free_id]     = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_tail      <= '0;
      r_size      <= '0;
      r_ck_valid  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tail      <= w_nxt_tail;
      r_size      <= w_nxt_size;
      r_ck_valid  <= w_nxt_valid;
      r_overflow  <= w_ovf;
      r_underflow <= w_unf;
    end
  end

  // Storage arrays carry no reset; the push write is last so it wins over the repair.
  always_ff @(posedge clk_in) begin
    if (rst_N_in) begin
      if (w_rst_ok) r_entries[r_ck_tail[restore_id_in]] <= r_ck_top[restore_id_in];
      if (w_wr_en)  r_entries[w_wr_addr] <= push_data_in;
      if (w_alloc) begin
        r_ck_tail[w_free_id] <= w_nxt_tail;
        r_ck_size[w_free_id] <= w_nxt_size;
        r_ck_top[w_free_id]  <= w_nxt_top;
      end
    end
  end

  assign top_out        = r_entries[r_tail];
  assign empty_out      = (r_size == '0);
  assign size_out       = r_size;
  assign overflow_out   = r_overflow;
  assign underflow_out  = r_underflow;
  assign ckpt_ready_out = w_ready;
  assign ckpt_id_out    = w_free_id;

endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
- Parametrised circular return-address stack for the fetch/branch-prediction front end; call pushes a return address, return pops it.
- Adds multi-slot speculative checkpointing: a branch takes a checkpoint ID, and a mispredict restores pointer, size and top entry from that ID in one cycle.
- Overflow wraps and overwrites the oldest entry. Underflow and overflow are reported.

Parameters:
- STACK_DEPTH, 16, number of entries; must be a power of two ≥ 2.
- ENTRY_SIZE, 64, return-address width in bits.
- NUM_CKPT, 4, number of checkpoint slots; ≥ 1.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_N_in  input  1  synchronous, active-low reset.
- push_in  input  1  call: push push_data_in.
- pop_in  input  1  return: pop top.
- push_data_in  input  ENTRY_SIZE  address to push.
- ckpt_req_in  input  1  request a checkpoint this cycle.
- ckpt_ready_out  output  1  at least one free checkpoint slot.
- ckpt_id_out  output  $clog2(NUM_CKPT) (min 1)  ID granted when ckpt_req_in && ckpt_ready_out.
- restore_in  input  1  restore from restore_id_in.
- restore_id_in  input  $clog2(NUM_CKPT) (min 1)  checkpoint to restore.
- release_in  input  1  free checkpoint release_id_in.
- release_id_in  input  $clog2(NUM_CKPT) (min 1)  checkpoint to free.
- top_out  output  ENTRY_SIZE  entry at tail; predicted return address.
- empty_out  output  1  size == 0.
- size_out  output  $clog2(STACK_DEPTH+1)  valid entry count, saturating at STACK_DEPTH.
- overflow_out  output  1  registered one-cycle pulse: a push overwrote a valid entry.
- underflow_out  output  1  registered one-cycle pulse: pop while empty.

Behaviour:
- State:
  - entries[STACK_DEPTH], not reset.
  - tail, $clog2(STACK_DEPTH) bits; points at the top entry.
  - size.
  - Per checkpoint slot: valid bit, saved tail, saved size, saved top entry.
- Reset (rst_N_in = 0 at posedge):
  - tail = 0, size = 0, all checkpoint valid bits = 0, overflow_out = 0, underflow_out = 0.
  - Resulting outputs: empty_out = 1, size_out = 0, ckpt_ready_out = 1, ckpt_id_out = 0.
  - top_out is don't-care while empty.
  - Reset mid-operation discards all in-flight checkpoints.
- Outputs:
  - top_out, empty_out, size_out are combinational from registered state; zero latency.
  - A pushed value appears on top_out the cycle after the push.
- Update order within one cycle:
  1. Restore.
  2. Push/pop applied on top of the restored state.
  3. Checkpoint capture of the resulting next state.
  4. Release / allocate bookkeeping.
- Restore, when restore_in is set and the slot is valid:
  - tail = saved tail, size = saved size.
  - entries[saved tail] = saved top, repairing a speculatively overwritten top.
  - The restored slot is freed.
  - If the slot is not valid, the restore is ignored and push/pop apply to the current state.
- Push only:
  - tail += 1 (mod depth); entries[tail+1] = push_data_in.
  - size += 1, saturating at STACK_DEPTH.
  - Pushing at size == STACK_DEPTH sets overflow_out on the next cycle.
- Pop only:
  - If size > 0: tail -= 1 (mod depth), size -= 1.
  - If size == 0: tail and size unchanged; underflow_out pulses.
- Push and pop together:
  - If size > 0: entries[tail] = push_data_in; tail and size unchanged.
  - If size == 0: behaves as a push (size becomes 1) and underflow_out pulses.
- Checkpoint capture:
  - Handshake is ckpt_req_in && ckpt_ready_out.
  - ckpt_id_out = lowest-index free slot, computed from the registered valid mask.
  - The slot stores the post-update tail, size and top entry (the newly pushed data if a push occurred).
  - The slot becomes valid next cycle.
  - If the request is made while ckpt_ready_out = 0, it is dropped and no state changes.
- Release:
  - Clears the slot's valid bit next cycle.
  - A slot freed this cycle is not allocatable until next cycle.
  - Release of an invalid slot is a no-op.
  - Release and allocate of different slots in the same cycle are both honoured.
  - Restore and release of the same ID in the same cycle: the restore applies, and the slot ends up free.
- Freeing younger checkpoints after a restore is the owner's responsibility via release_in.
- All pointer arithmetic is modulo STACK_DEPTH; size never exceeds STACK_DEPTH and never underflows.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles -> top_out = 0xC, size_out = 3; three pops -> top_out 0xB, then 0xA, then empty_out = 1; a fourth pop -> underflow_out = 1 for one cycle, size_out stays 0.
- DEPTH = 4: push 1..5 -> overflow_out pulses on the 5th push, size_out = 4, top_out = 5; four pops yield 5, 4, 3, 2, then empty_out = 1.
- Push 0x10, 0x20; ckpt_req (id 0); pop; push 0x99 (overwrites 0x20's slot); restore id 0 -> top_out = 0x20, size_out = 2, slot 0 free, ckpt_ready_out = 1.
- Push and pop together with top 0x20 and data 0x77 -> top_out = 0x77, size_out unchanged; the same with an empty stack -> size_out = 1, top_out = 0x77, underflow_out pulses.
- NUM_CKPT = 4: four requests -> IDs 0, 1, 2, 3 granted, then ckpt_ready_out = 0 and a 5th request is dropped; release 2 -> next grant is ID 2.
- Restore id 1 with push 0x55 and ckpt_req in the same cycle -> restored state plus the push is applied, and the new checkpoint captures that post-update state (top 0x55).
